// File: rtl/tdm_domain_arb_pkg.sv
// Shared TDM slot-state encodings and sizing helper for the domain arbiter and ring routers.
package tdm_domain_arb_pkg;

    typedef enum logic [1:0] {
        SLOT_L  = 2'd0,
        GUARD_L = 2'd1,
        SLOT_H  = 2'd2,
        GUARD_H = 2'd3
    } tdm_state_e;

    // Counter must hold the longest state duration minus one, never narrower than 1 bit.
    function automatic int cnt_width(input int slot_len, input int guard_len);
        int m;
        m = (slot_len > guard_len) ? slot_len : guard_len;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/tdm_domain_arb_slot_timer.sv
// Fixed-schedule slot/guard sequencer: SLOT_L, GUARD_L, SLOT_H, GUARD_H, driven only by its counter.
module tdm_slot_timer
    import tdm_domain_arb_pkg::*;
#(
    parameter int p_slot_len  = 8,
    parameter int p_guard_len = 2
) (
    input  logic       clk,
    input  logic       reset,
    output tdm_state_e state,
    output logic       domain,
    output logic       slot_start
);

    localparam int CW = cnt_width(p_slot_len, p_guard_len);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(p_slot_len - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((p_guard_len > 0) ? p_guard_len - 1 : 0);

    tdm_state_e    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          in_slot;
    logic          last;

    assign in_slot = (state == SLOT_L) || (state == SLOT_H);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SLOT_L;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        last       = in_slot ? (cnt == SLOT_LAST) : (cnt == GUARD_LAST);
        if (last) begin
            cnt_next = '0;
            // A zero-length guard is skipped entirely rather than lasting one cycle.
            case (state)
                SLOT_L:  state_next = (p_guard_len == 0) ? SLOT_H : GUARD_L;
                GUARD_L: state_next = SLOT_H;
                SLOT_H:  state_next = (p_guard_len == 0) ? SLOT_L : GUARD_H;
                default: state_next = SLOT_L;
            endcase
        end
    end

    always_comb begin
        domain     = reset && ((state == SLOT_H) || (state == GUARD_H));
        slot_start = reset && in_slot && (cnt == '0);
    end

endmodule

// File: rtl/tdm_domain_arb.sv
// Two-domain TDM arbiter: each domain owns a round-robin priority and only wins grants in its own slot.
module tdm_domain_arb
    import tdm_domain_arb_pkg::*;
#(
    parameter int p_num_reqs  = 4,
    parameter int p_slot_len  = 8,
    parameter int p_guard_len = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [p_num_reqs-1:0] reqs_l,
    input  logic [p_num_reqs-1:0] reqs_h,
    output logic                  domain,
    output logic [p_num_reqs-1:0] grants,
    output logic                  slot_start
);

    localparam int N = p_num_reqs;
    localparam logic [N-1:0] PRIO_INIT = {{(N-1){1'b0}}, 1'b1};

    tdm_state_e   state;
    logic [N-1:0] prio_l;
    logic [N-1:0] prio_h;
    logic [N-1:0] grant_l;
    logic [N-1:0] grant_h;

    // First requester at or after the one-hot priority position, wrapping upward.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input logic [N-1:0] prio);
        logic [N-1:0] g;
        logic         found;
        int           idx;
        g     = '0;
        found = 1'b0;
        for (int base = 0; base < N; base++) begin
            if (prio[base]) begin
                for (int off = 0; off < N; off++) begin
                    idx = (base + off) % N;
                    if (!found && req[idx]) begin
                        g[idx] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
        end
        return g;
    endfunction

    tdm_slot_timer #(
        .p_slot_len  (p_slot_len),
        .p_guard_len (p_guard_len)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .domain     (domain),
        .slot_start (slot_start)
    );

    // Reset gates grants combinationally so an asserted reset kills them within the cycle.
    always_comb begin
        grant_l = (reset && (state == SLOT_L)) ? rr_pick(reqs_l, prio_l) : '0;
        grant_h = (reset && (state == SLOT_H)) ? rr_pick(reqs_h, prio_h) : '0;
        grants  = grant_l | grant_h;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_l <= PRIO_INIT;
            prio_h <= PRIO_INIT;
        end else begin
            if (|grant_l) prio_l <= {grant_l[N-2:0], grant_l[N-1]};
            if (|grant_h) prio_h <= {grant_h[N-2:0], grant_h[N-1]};
        end
    end

endmodule
